// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for the motion estimator core: one search per block, results queued in a FIFO.
// Optional ME_SCHED_STATS_EN adds perfect_count/miss_count statistics outputs.
module me_frame_scheduler #(
  parameter int unsigned SEARCH_CYCLES = 4112,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [7:0]  num_blocks,
  output logic        busy,
  output logic        frame_done,
  output logic        me_start,
  output logic [7:0]  block_index,
  input  logic [7:0]  me_BestDist,
  input  logic [3:0]  me_motionX,
  input  logic [3:0]  me_motionY,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [23:0] res_data
`ifdef ME_SCHED_STATS_EN
  ,
  output logic [7:0]  perfect_count,
  output logic [7:0]  miss_count
`endif
);

  localparam int unsigned CW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(SEARCH_CYCLES - 1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    nblk_q;
  logic [7:0]    blk_q;
  logic          busy_q;
  logic          done_q;
  logic          start_q;

  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic          full;
  logic          push;
  logic          pop;
  logic          accept;
  logic [23:0]   push_data;

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign me_start    = start_q;
  assign block_index = blk_q;
  assign res_valid   = (occ_q != '0);
  assign res_data    = mem_q[rd_q];

  // Fullness is taken from the registered occupancy, so a same-cycle pop never frees a slot for this push.
  always_comb begin
    full      = (occ_q == OCC_FULL);
    push      = (state_q == S_CAPTURE) && !full;
    pop       = res_valid && res_ready;
    accept    = (state_q == S_IDLE) && frame_start;
    push_data = {blk_q, me_BestDist, me_motionX, me_motionY};
    wr_d      = push ? wr_q + 1'b1 : wr_q;
    rd_d      = pop ? rd_q + 1'b1 : rd_q;
    occ_d     = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      if (push) begin
        mem_q[wr_q] <= push_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nblk_q  <= '0;
      blk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (frame_start) begin
            nblk_q <= num_blocks;
            blk_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (num_blocks == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              start_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
            state_q <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (push) begin
            if (blk_q == 8'(nblk_q - 8'd1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              blk_q   <= blk_q + 8'd1;
              start_q <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ME_SCHED_STATS_EN
  logic [7:0] perfect_q;
  logic [7:0] miss_q;

  assign perfect_count = perfect_q;
  assign miss_count    = miss_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perfect_q <= '0;
      miss_q    <= '0;
    end else if (accept) begin
      perfect_q <= '0;
      miss_q    <= '0;
    end else if (push) begin
      if ((me_BestDist == 8'h00) && (perfect_q != 8'hFF)) begin
        perfect_q <= perfect_q + 8'd1;
      end
      if ((me_BestDist == 8'hFF) && (miss_q != 8'hFF)) begin
        miss_q <= miss_q + 8'd1;
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Scoreboard bench for me_frame_scheduler: stimulus queues expected results, a monitor checks FIFO pops.
module tb_me_frame_scheduler;

  localparam int unsigned SC    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          BLK   = SC + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [7:0]  num_blocks = '0;
  logic        busy, frame_done, me_start, res_valid;
  logic [7:0]  block_index;
  logic [7:0]  me_BestDist;
  logic [3:0]  me_motionX, me_motionY;
  logic        res_ready = 1'b0;
  logic [23:0] res_data;
`ifdef ME_SCHED_STATS_EN
  logic [7:0]  perfect_count, miss_count;
`endif

  me_frame_scheduler #(.SEARCH_CYCLES(SC), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .num_blocks(num_blocks),
    .busy(busy), .frame_done(frame_done), .me_start(me_start), .block_index(block_index),
    .me_BestDist(me_BestDist), .me_motionX(me_motionX), .me_motionY(me_motionY),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef ME_SCHED_STATS_EN
    , .perfect_count(perfect_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  logic [7:0] bd_tab [8];
  logic [3:0] x_tab  [8];
  logic [3:0] y_tab  [8];

  always_comb begin
    me_BestDist = bd_tab[block_index[2:0]];
    me_motionX  = x_tab[block_index[2:0]];
    me_motionY  = y_tab[block_index[2:0]];
  end

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q [$];

  int cyc = 0;
  int ms_total = 0, busy_total = 0, done_cnt = 0, last_done = 0;
  int pop_cnt = 0, gap_len = 0, last_gap = 0;
  logic ms_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (me_start) ms_total++;
    if (busy) busy_total++;
    if (frame_done) begin
      done_cnt++;
      last_done = cyc;
    end
    if (me_start) begin
      if (!ms_prev) last_gap = gap_len;
      gap_len = 0;
    end else begin
      gap_len++;
    end
    ms_prev = me_start;
    if (res_valid && res_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got 0x%0h, expected no result", res_data);
      end else begin
        chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_blk(input int i, input logic [7:0] bd, input logic [3:0] x, input logic [3:0] y);
    bd_tab[i] = bd;
    x_tab[i]  = x;
    y_tab[i]  = y;
  endtask

  task automatic start_frame(input logic [7:0] n, input bit queue_results, output int acc);
    logic [7:0] ib;
    @(posedge clock); #1;
    frame_start = 1'b1;
    num_blocks  = n;
    acc         = cyc;
    if (queue_results) begin
      for (int i = 0; i < int'(n); i++) begin
        ib = 8'(i);
        exp_q.push_back({ib, bd_tab[ib[2:0]], x_tab[ib[2:0]], y_tab[ib[2:0]]});
      end
    end
    @(posedge clock); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int k;
    k = 0;
    while ((done_cnt == d0) && (k < limit)) begin
      @(posedge clock); #1;
      k++;
    end
    chk("frame_done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d0, m0, b0, p0;
    for (int i = 0; i < 8; i++) set_blk(i, 8'h00, 4'h0, 4'h0);

    // reset state
    cycles(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_me_start", 32'(me_start), 32'd0);
    chk("rst_block_index", 32'(block_index), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    reset = 1'b0;
    cycles(2);

    // single block
    set_blk(0, 8'h00, 4'h3, 4'hE);
    res_ready = 1'b1;
    m0 = ms_total; d0 = done_cnt; p0 = pop_cnt;
    exp_q.push_back(24'h00003E);
    start_frame(8'd1, 1'b0, acc);
    wait_done(d0, 100);
    chk("t1_done_latency", 32'(last_done - acc), 32'd11);
    chk("t1_me_start_cycles", 32'(ms_total - m0), 32'd8);
    cycles(3);
    chk("t1_pops", 32'(pop_cnt - p0), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // three blocks
    set_blk(0, 8'h10, 4'h1, 4'h2);
    set_blk(1, 8'hA5, 4'h7, 4'h8);
    set_blk(2, 8'h3C, 4'hF, 4'h9);
    m0 = ms_total; d0 = done_cnt; p0 = pop_cnt;
    start_frame(8'd3, 1'b1, acc);
    wait_done(d0, 200);
    chk("t2_done_latency", 32'(last_done - acc), 32'd31);
    chk("t2_me_start_cycles", 32'(ms_total - m0), 32'd24);
    chk("t2_gap", 32'(last_gap), 32'd2);
    cycles(3);
    chk("t2_pops", 32'(pop_cnt - p0), 32'd3);
    chk("t2_block_index_hold", 32'(block_index), 32'd2);

    // backpressure with six blocks into a four-entry FIFO
    res_ready = 1'b0;
    set_blk(0, 8'h01, 4'h1, 4'hE);
    set_blk(1, 8'h02, 4'h2, 4'hD);
    set_blk(2, 8'h03, 4'h3, 4'hC);
    set_blk(3, 8'h04, 4'h4, 4'hB);
    set_blk(4, 8'h05, 4'h5, 4'hA);
    set_blk(5, 8'h06, 4'h6, 4'h9);
    d0 = done_cnt; p0 = pop_cnt;
    start_frame(8'd6, 1'b1, acc);
    cycles(5 * BLK + 4);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    chk("t3_stall_me_start", 32'(me_start), 32'd0);
    chk("t3_stall_block", 32'(block_index), 32'd4);
    chk("t3_stall_valid", 32'(res_valid), 32'd1);
    chk("t3_head", 32'(res_data), 32'h00011E);
    cycles(3);
    chk("t3_head_stable", 32'(res_data), 32'h00011E);
    chk("t3_no_done_yet", 32'(done_cnt - d0), 32'd0);
    res_ready = 1'b1;
    wait_done(d0, 200);
    cycles(3);
    chk("t3_pops", 32'(pop_cnt - p0), 32'd6);
    chk("t3_empty", 32'(res_valid), 32'd0);

    // empty frame
    m0 = ms_total; b0 = busy_total; d0 = done_cnt; p0 = pop_cnt;
    start_frame(8'd0, 1'b1, acc);
    wait_done(d0, 20);
    chk("t4_done_latency", 32'(last_done - acc), 32'd1);
    cycles(3);
    chk("t4_busy_cycles", 32'(busy_total - b0), 32'd1);
    chk("t4_me_start_cycles", 32'(ms_total - m0), 32'd0);
    chk("t4_pops", 32'(pop_cnt - p0), 32'd0);

    // reset in the middle of RUN at count 5
    set_blk(0, 8'h44, 4'h2, 4'h3);
    set_blk(1, 8'h55, 4'h4, 4'h5);
    start_frame(8'd2, 1'b0, acc);
    cycles(5);
    reset = 1'b1;
    #1;
    chk("t5_rst_outputs", 32'({busy, frame_done, me_start, block_index, res_valid}), 32'd0);
    chk("t5_rst_res_data", 32'(res_data), 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(2);
    d0 = done_cnt; p0 = pop_cnt;
    start_frame(8'd2, 1'b1, acc);
    cycles(10);
    frame_start = 1'b1;
    num_blocks  = 8'd5;
    cycles(1);
    frame_start = 1'b0;
    wait_done(d0, 100);
    chk("t5_done_latency", 32'(last_done - acc), 32'd21);
    cycles(2 * BLK);
    chk("t5_single_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_pops", 32'(pop_cnt - p0), 32'd2);

    // statistics frame
    set_blk(0, 8'h00, 4'h1, 4'h1);
    set_blk(1, 8'hFF, 4'h8, 4'h7);
    set_blk(2, 8'h12, 4'hC, 4'h4);
    set_blk(3, 8'h00, 4'h0, 4'hF);
    d0 = done_cnt;
    start_frame(8'd4, 1'b1, acc);
    wait_done(d0, 200);
    chk("t6_done_latency", 32'(last_done - acc), 32'd41);
`ifdef ME_SCHED_STATS_EN
    chk("t6_perfect_count", 32'(perfect_count), 32'd2);
    chk("t6_miss_count", 32'(miss_count), 32'd1);
`endif
    cycles(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
